// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD sequencer: state encoding, init command ROM,
// HD44780 command constants and the predicate that picks the long post-command wait.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_SETUP   = 3'd1,
        ST_PULSE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_IDLE    = 3'd4
    } state_t;

    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME      = 8'h02;
    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

    localparam logic [1:0] INIT_LAST_IDX = 2'd3;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = LCD_FUNC_8B2L;
            2'd1:    b = LCD_DISP_ON;
            2'd2:    b = LCD_CLEAR;
            default: b = LCD_ENTRY_INC;
        endcase
        return b;
    endfunction

    // Clear and both encodings of return-home need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CLEAR) || (data == LCD_HOME) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter: combinational one-hot grant, bit 0 = port A, bit 1 = port B.
// When both request, the port that was not granted last time wins.
module lcd_rr_arbiter (
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/lcd_sequencer.sv
// Owns the write-only 8-bit LCD bus: power-up delay, fixed init list, then round-robin byte
// writes from ports A/B; a request is accepted only in IDLE and each access takes setup+pulse+wait.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP  = 750000,
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_EN_PULSE = 25,
    parameter int unsigned T_CMD      = 2000,
    parameter int unsigned T_CLEAR    = 82000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic       a_rs,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_rs,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_data_bus,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam bit PARAMS_OK =
        (CNT_W >= 1) && (CNT_W <= 32) &&
        (T_POWERUP  != 0) && (64'(T_POWERUP)  <= CNT_MAX) &&
        (T_SETUP    != 0) && (64'(T_SETUP)    <= CNT_MAX) &&
        (T_EN_PULSE != 0) && (64'(T_EN_PULSE) <= CNT_MAX) &&
        (T_CMD      != 0) && (64'(T_CMD)      <= CNT_MAX) &&
        (T_CLEAR    != 0) && (64'(T_CLEAR)    <= CNT_MAX);

    if (!PARAMS_OK) begin : g_bad_params
        $error("lcd_sequencer: every T_* must be nonzero and fit in CNT_W bits");
    end

    // Each phase ends when the counter reaches its length minus one.
    localparam logic [CNT_W-1:0] LAST_PWR   = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] LAST_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LAST_PULSE = CNT_W'(T_EN_PULSE - 1);
    localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LAST_CLEAR = CNT_W'(T_CLEAR - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_q, init_d;
    logic [1:0]       idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             last_b_q, last_b_d;

    logic [CNT_W-1:0] phase_last;
    logic             phase_end;
    logic             accept_en;
    logic [1:0]       grant;

    assign accept_en = (state_q == ST_IDLE) && init_done_q;

    lcd_rr_arbiter u_arb (
        .req_i        ({b_valid, a_valid}),
        .en_i         (accept_en),
        .last_grant_i (last_b_q),
        .grant_o      (grant)
    );

    always_comb begin
        phase_last = '0;
        case (state_q)
            ST_POWERUP: phase_last = LAST_PWR;
            ST_SETUP:   phase_last = LAST_SETUP;
            ST_PULSE:   phase_last = LAST_PULSE;
            ST_WAIT:    phase_last = is_slow_cmd(rs_q, data_q) ? LAST_CLEAR : LAST_CMD;
            default:    phase_last = '0;
        endcase
    end

    assign phase_end = (cnt_q == phase_last);

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        data_d      = data_q;
        rs_d        = rs_q;
        last_b_d    = last_b_q;

        case (state_q)
            ST_POWERUP: begin
                if (phase_end) begin
                    state_d = ST_SETUP;
                    idx_d   = 2'd0;
                    data_d  = init_byte(2'd0);
                    rs_d    = 1'b0;
                end
            end
            ST_SETUP: begin
                if (phase_end) state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (phase_end) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (phase_end) begin
                    if (init_q && (idx_q != INIT_LAST_IDX)) begin
                        idx_d   = idx_q + 2'd1;
                        data_d  = init_byte(idx_q + 2'd1);
                        rs_d    = 1'b0;
                        state_d = ST_SETUP;
                    end else begin
                        if (init_q) init_done_d = 1'b1;
                        init_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (grant[0]) begin
                    data_d   = a_data;
                    rs_d     = a_rs;
                    last_b_d = 1'b0;
                    state_d  = ST_SETUP;
                end else if (grant[1]) begin
                    data_d   = b_data;
                    rs_d     = b_rs;
                    last_b_d = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            default: state_d = ST_POWERUP;
        endcase

        if ((state_d != state_q) || (state_q == ST_IDLE)) cnt_d = '0;
        else                                                cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_POWERUP;
            cnt_q       <= '0;
            init_q      <= 1'b1;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            last_b_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_q      <= init_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            last_b_q    <= last_b_d;
        end
    end

    assign a_ready      = accept_en;
    assign b_ready      = accept_en;
    assign init_done    = init_done_q;
    assign busy         = (state_q != ST_IDLE);
    assign lcd_e        = (state_q == ST_PULSE);
    assign lcd_data_bus = data_q;
    assign lcd_rs       = rs_q;
    assign lcd_rw       = 1'b0;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: directed init/transfer tables, reset-mid-pulse sequence, then a
// randomized two-port run checked against a cycle-timeline model of the access timing.
module tb_lcd_sequencer;

    localparam int T_POWERUP = 20;
    localparam int T_SETUP   = 2;
    localparam int T_EN      = 4;
    localparam int T_CMD     = 10;
    localparam int T_CLEAR   = 30;
    localparam int INIT_TIME = T_POWERUP + 4 * (T_SETUP + T_EN) + 3 * T_CMD + T_CLEAR;
    localparam int BOUND     = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0, a_rs = 1'b0, b_valid = 1'b0, b_rs = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_ready, b_ready, init_done, busy, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data_bus;

    lcd_sequencer #(
        .T_POWERUP  (T_POWERUP),
        .T_SETUP    (T_SETUP),
        .T_EN_PULSE (T_EN),
        .T_CMD      (T_CMD),
        .T_CLEAR    (T_CLEAR),
        .CNT_W      (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_rs         (a_rs),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_rs         (b_rs),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .init_done    (init_done),
        .busy         (busy),
        .lcd_data_bus (lcd_data_bus),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_e        (lcd_e)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rw_high = 0;
    always @(negedge clk) if (lcd_rw !== 1'b0) rw_high <= rw_high + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } init_vec_t;

    typedef struct {
        int         port;
        logic       rs;
        logic [7:0] data;
        int         wt;
    } xfer_vec_t;

    init_vec_t init_tab[4];
    xfer_vec_t xfer_tab[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_e(input logic lvl, output int c);
        int n = 0;
        while (lcd_e !== lvl && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (lcd_e !== lvl) begin
            check("e_timeout", 32'd0, 32'd1);
            c = -100000;
        end else begin
            c = cyc;
        end
    endtask

    task automatic wait_ready(output int c);
        int n = 0;
        while (a_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (a_ready !== 1'b1) begin
            check("ready_timeout", 32'd0, 32'd1);
            c = -100000;
        end else begin
            c = cyc;
        end
    endtask

    task automatic do_reset(output int r);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs",
              {lcd_e, lcd_rs, lcd_data_bus, init_done, busy, a_ready, b_ready},
              {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        reset = 1'b0;
        r = cyc;
    endtask

    task automatic check_init(input int r, output int d);
        int ref_c, cr, cf, n;
        ref_c = r;
        for (int i = 0; i < 4; i++) begin
            wait_e(1'b1, cr);
            check($sformatf("init%0d_gap", i), cr - ref_c, init_tab[i].gap);
            check($sformatf("init%0d_bus", i), {lcd_rs, lcd_data_bus}, {1'b0, init_tab[i].data});
            check($sformatf("init%0d_rdy", i), {init_done, a_ready, b_ready}, 3'b000);
            wait_e(1'b0, cf);
            check($sformatf("init%0d_width", i), cf - cr, T_EN);
            ref_c = cf;
        end
        n = 0;
        while (init_done !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        d = cyc;
        check("init_done_delay", d - ref_c, T_CMD);
        check("idle_outs", {busy, a_ready, b_ready}, 3'b011);
    endtask

    task automatic do_xfer(input xfer_vec_t v);
        int k, cr, cf, cd;
        check("xfer_pre_ready", {a_ready, b_ready}, 2'b11);
        if (v.port == 0) begin
            a_valid = 1'b1; a_rs = v.rs; a_data = v.data;
        end else begin
            b_valid = 1'b1; b_rs = v.rs; b_data = v.data;
        end
        k = cyc + 1;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        a_data = 8'($urandom); b_data = 8'($urandom);
        a_rs = 1'($urandom); b_rs = 1'($urandom);
        check("xfer_ready_drop", {a_ready, b_ready, busy}, 3'b001);
        wait_e(1'b1, cr);
        check("xfer_rise", cr - k, T_SETUP);
        check("xfer_bus", {lcd_rs, lcd_data_bus}, {v.rs, v.data});
        wait_e(1'b0, cf);
        check("xfer_width", cf - cr, T_EN);
        check("xfer_bus_held", {lcd_rs, lcd_data_bus}, {v.rs, v.data});
        wait_ready(cd);
        check("xfer_wait", cd - cf, v.wt);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, d, cr, cf, cd, prev;
        int free_at, xk, n_x;
        logic       have_x, last_b, x_rs, exp_rdy, exp_e, slow;
        logic [1:0] pend;
        logic       prs [2];
        logic [7:0] pdat[2];
        logic [7:0] x_data;
        int         g;

        init_tab[0] = '{8'h38, T_POWERUP + T_SETUP};
        init_tab[1] = '{8'h0C, T_CMD + T_SETUP};
        init_tab[2] = '{8'h01, T_CMD + T_SETUP};
        init_tab[3] = '{8'h06, T_CLEAR + T_SETUP};

        xfer_tab[0] = '{0, 1'b1, 8'h41, T_CMD};
        xfer_tab[1] = '{1, 1'b0, 8'h01, T_CLEAR};
        xfer_tab[2] = '{1, 1'b0, 8'h80, T_CMD};

        // Power-up and init list with no requests.
        do_reset(r);
        check_init(r, d);

        for (int i = 0; i < 3; i++) do_xfer(xfer_tab[i]);

        // Both ports held valid: last grant was B, so A goes first and they alternate.
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h31;
        b_valid = 1'b1; b_rs = 1'b1; b_data = 8'h32;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_e(1'b1, cr);
            check($sformatf("rr%0d_bus", i), {lcd_rs, lcd_data_bus},
                  {1'b1, (i % 2 == 0) ? 8'h31 : 8'h32});
            if (i > 0) check($sformatf("rr%0d_spacing", i), cr - prev, T_SETUP + T_EN + T_CMD + 1);
            prev = cr;
            wait_e(1'b0, cf);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        wait_ready(cd);

        // Reset while E is high, with port A then requesting throughout the re-init.
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h77;
        @(negedge clk);
        a_valid = 1'b0;
        wait_e(1'b1, cr);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_pulse", {lcd_e, init_done, busy, lcd_data_bus}, {1'b0, 1'b0, 1'b1, 8'h00});
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h55;
        reset = 1'b0;
        r = cyc;
        check_init(r, d);
        @(negedge clk);
        a_valid = 1'b0;
        wait_e(1'b1, cr);
        check("post_init_accept", cr - (d + 1), T_SETUP);
        check("post_init_bus", {lcd_rs, lcd_data_bus}, {1'b1, 8'h55});
        wait_e(1'b0, cf);
        wait_ready(cd);

        // Randomized two-port traffic from a fresh reset, against a timeline model.
        do_reset(r);
        free_at = r + INIT_TIME;
        last_b  = 1'b1;
        have_x  = 1'b0;
        pend    = 2'b00;
        xk = 0; x_rs = 1'b0; x_data = 8'h00; n_x = 0;
        prs[0] = 1'b0; prs[1] = 1'b0; pdat[0] = 8'h00; pdat[1] = 8'h00;
        for (int step = 0; step < 3000; step++) begin
            exp_rdy = (cyc >= free_at);
            check("rand_ready", {a_ready, b_ready}, {exp_rdy, exp_rdy});
            if (have_x) begin
                exp_e = (cyc >= xk + T_SETUP) && (cyc < xk + T_SETUP + T_EN);
                check("rand_e", lcd_e, exp_e);
                check("rand_bus", {lcd_rs, lcd_data_bus}, {x_rs, x_data});
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    pend[p] = 1'b1;
                    prs[p]  = 1'($urandom_range(0, 1));
                    pdat[p] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
                end
            end
            a_valid = pend[0]; a_rs = pend[0] ? prs[0] : 1'($urandom);
            a_data  = pend[0] ? pdat[0] : 8'($urandom);
            b_valid = pend[1]; b_rs = pend[1] ? prs[1] : 1'($urandom);
            b_data  = pend[1] ? pdat[1] : 8'($urandom);
            if (exp_rdy && pend != 2'b00) begin
                if (pend == 2'b11) g = last_b ? 0 : 1;
                else               g = pend[1] ? 1 : 0;
                xk      = cyc + 1;
                x_rs    = prs[g];
                x_data  = pdat[g];
                slow    = !x_rs && (x_data inside {8'h01, 8'h02, 8'h03});
                free_at = xk + T_SETUP + T_EN + (slow ? T_CLEAR : T_CMD);
                last_b  = (g == 1);
                pend[g] = 1'b0;
                have_x  = 1'b1;
                n_x++;
            end
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        check("rand_xfer_count", {31'd0, n_x > 30}, 32'd1);
        check("lcd_rw_low", rw_high, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
Owns the HD44780-style character LCD bus (8-bit, write-only) and sequences every access with correct setup, enable-pulse and execution timing. After reset it runs the power-up delay and a fixed init command list. It then serves byte writes from two requesters: port A (CPU control unit, DISPLAY/CLEAR ops) and port B (display refresh logic), using round-robin arbitration and a valid/ready handshake. The control unit no longer drives lcd_e or lcd_data_bus directly.

Parameters:
T_POWERUP, 750000, cycles of idle bus after reset before the first init command (15 ms @ 50 MHz)
T_SETUP, 2, cycles RS/data are stable with E low before E rises
T_EN_PULSE, 25, cycles E is held high
T_CMD, 2000, post-pulse wait for normal commands and data (40 us)
T_CLEAR, 82000, post-pulse wait for clear (0x01) and home (0x02/0x03) commands (1.64 ms)
CNT_W, 20, delay counter width; every T_* value must fit in CNT_W bits (elaboration check)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
a_valid  in  1  port A request
a_rs  in  1  port A register select (0 = command, 1 = data)
a_data  in  8  port A byte
a_ready  out  1  port A accepted when a_valid & a_ready
b_valid  in  1  port B request
b_rs  in  1  port B register select
b_data  in  8  port B byte
b_ready  out  1  port B accepted when b_valid & b_ready
init_done  out  1  init sequence complete, sticky until reset
busy  out  1  high in every state except IDLE
lcd_data_bus  out  8  LCD DB7..DB0
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write, always 0
lcd_e  out  1  LCD enable strobe

Behaviour:
- Only clk is used. Reset is synchronous and active-high. Reset asserted in any state, including mid-pulse, makes the next state POWERUP. On that edge: lcd_e=0, lcd_data_bus=0x00, lcd_rs=0, lcd_rw=0, a_ready=b_ready=0, init_done=0, busy=1, init index=0, counter=0, last_grant=B.
- States: POWERUP, SETUP, PULSE, WAIT, IDLE. A 1-bit init flag selects the init list or a latched request as the byte source.
- POWERUP: outputs held at reset values for T_POWERUP cycles. Then load init byte 0, rs=0, go to SETUP.
- Init list: 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment).
- SETUP: drive data and rs, E=0, for T_SETUP cycles, then go to PULSE.
- PULSE: E=1 for T_EN_PULSE cycles, data and rs held, then go to WAIT.
- WAIT: E=0, data and rs held. Duration is T_CLEAR if rs=0 and data is 0x01, 0x02 or 0x03; otherwise T_CMD. On completion:
  - In init with index<3: increment index, go to SETUP with the next byte.
  - In init with index=3: set init_done, go to IDLE.
  - Otherwise: go to IDLE.
- IDLE: a_ready = b_ready = 1 only when init_done=1 and state is IDLE. Ready is combinational from state, never from valid.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the port that is not last_grant.
  - On grant: latch data and rs, update last_grant, go to SETUP the next cycle. Both readys drop the cycle after acceptance.
- Exactly one handshake per IDLE cycle. The non-granted port keeps valid asserted and is served next.
- Latency: accept at edge k. E rises at edge k+T_SETUP and falls at edge k+T_SETUP+T_EN_PULSE. Ready reasserts after a further T_CMD or T_CLEAR cycles.
- Requests during init or a transfer are not accepted (ready=0). Inputs are ignored unless handshaken.
- Counter: counts up from 0 and is cleared on every state change. A phase ends when count = T_x - 1, so each phase lasts exactly T_x cycles.

Decomposition:
- Package lcd_pkg holds:
  - state encoding
  - init command ROM (4 x 8 bit)
  - command constants: LCD_CLEAR=0x01, LCD_HOME=0x02, LCD_FUNC_8B2L=0x38, LCD_DISP_ON=0x0C, LCD_ENTRY_INC=0x06
  - slow-command predicate function
- One sub-module: lcd_rr_arbiter. It is a 2-way round-robin arbiter with inputs req[1:0], enable and last_grant register, and outputs a one-hot grant. It is instantiated once.

Test Plan (sim parameters: T_POWERUP=20, T_SETUP=2, T_EN_PULSE=4, T_CMD=10, T_CLEAR=30):
1. Reset released, no requests -> E stays 0 for 20 cycles, then exactly 4 E pulses of 4 cycles carrying 0x38, 0x0C, 0x01, 0x06 with rs=0. The gap after 0x01 is 30 cycles; the others are 10. init_done rises after the last wait; readys are 0 until then.
2. After init, a_valid with rs=1, data=0x41 -> accepted in 1 cycle. E high exactly 4 cycles, 2 cycles after acceptance, with bus=0x41 and rs=1. a_ready returns 16 cycles after acceptance.
3. a_valid and b_valid held together from IDLE (A: 0x31, B: 0x32, rs=1) -> order A, B, A, B over four transfers. Never two handshakes in one cycle.
4. Port B sends command 0x01 (rs=0) -> post-pulse wait is 30 cycles. Port B then sends 0x80 -> wait is 10 cycles.
5. Reset asserted while E=1 during a port A transfer -> E=0 on the next edge, init_done=0, and the full init sequence repeats from POWERUP.
6. a_valid asserted during init -> no handshake occurs. It is accepted in the first IDLE cycle after init_done; lcd_rw is 0 throughout.
